// File: rtl/video_pkg.sv
// Shared constants, pattern modes and colour-bar table
// for the test-pattern generator.
package video_pkg;

    localparam int H_VISIBLE = 1280;
    localparam int V_VISIBLE = 720;
    localparam int BAR_WIDTH = H_VISIBLE / 8;

    typedef enum logic [1:0] {
        PAT_BARS,
        PAT_GRAD,
        PAT_CHECK,
        PAT_BOX
    } pattern_mode_t;

    // Index 0 is the leftmost bar (white), index 7 the rightmost (black).
    localparam logic [7:0][23:0] BAR_TABLE = {
        24'h000000,
        24'h0000FF,
        24'hFF0000,
        24'hFF00FF,
        24'h00FF00,
        24'h00FFFF,
        24'hFFFF00,
        24'hFFFFFF
    };

    // Divide by the bar width with a chain of constant compares.
    function automatic logic [2:0] bar_index(input logic [11:0] x);
        logic [2:0] idx;
        idx = 3'd7;
        for (int k = 6; k >= 0; k--) begin
            if (x < 12'((k + 1) * BAR_WIDTH))
                idx = 3'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Timing-in / pixel-out bundle between the timing
// generator and the pattern generator.
interface video_pattern_gen_if;

    logic        hs_in;
    logic        vs_in;
    logic [11:0] x_in;
    logic [9:0]  y_in;
    logic        active_in;
    logic [5:0]  fc_in;
    logic [1:0]  mode_in;

    logic [7:0]  red_out;
    logic [7:0]  green_out;
    logic [7:0]  blue_out;
    logic        hs_out;
    logic        vs_out;
    logic        de_out;

    modport master (
        output hs_in, vs_in, x_in, y_in,
        output active_in, fc_in, mode_in,
        input  red_out, green_out, blue_out,
        input  hs_out, vs_out, de_out
    );

    modport slave (
        input  hs_in, vs_in, x_in, y_in,
        input  active_in, fc_in, mode_in,
        output red_out, green_out, blue_out,
        output hs_out, vs_out, de_out
    );

endinterface

// File: rtl/pattern_box_mover.sv
// Bouncing-box position, stepped once per frame and
// clamped to the visible area.
module pattern_box_mover #(
    parameter int H_VISIBLE = video_pkg::H_VISIBLE,
    parameter int V_VISIBLE = video_pkg::V_VISIBLE,
    parameter int BOX_SIZE  = 64,
    parameter int BOX_STEP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    output logic [10:0] box_x,
    output logic [9:0]  box_y
);

    localparam int X_MAX = H_VISIBLE - BOX_SIZE;
    localparam int Y_MAX = V_VISIBLE - BOX_SIZE;

    logic        dir_x;
    logic        dir_y;
    logic [11:0] x_fwd;
    logic [10:0] y_fwd;

    // One spare bit so the forward step can never wrap.
    assign x_fwd = {1'b0, box_x} + 12'(BOX_STEP);
    assign y_fwd = {1'b0, box_y} + 11'(BOX_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            box_x <= '0;
            box_y <= '0;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (frame_tick) begin
            if (dir_x) begin
                if (x_fwd > 12'(X_MAX)) begin
                    box_x <= 11'(X_MAX);
                    dir_x <= 1'b0;
                end else begin
                    box_x <= x_fwd[10:0];
                end
            end else if (box_x < 11'(BOX_STEP)) begin
                box_x <= '0;
                dir_x <= 1'b1;
            end else begin
                box_x <= box_x - 11'(BOX_STEP);
            end

            if (dir_y) begin
                if (y_fwd > 11'(Y_MAX)) begin
                    box_y <= 10'(Y_MAX);
                    dir_y <= 1'b0;
                end else begin
                    box_y <= y_fwd[9:0];
                end
            end else if (box_y < 10'(BOX_STEP)) begin
                box_y <= '0;
                dir_y <= 1'b1;
            end else begin
                box_y <= box_y - 10'(BOX_STEP);
            end
        end
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Two-stage test-pattern generator: bars, gradient,
// checker and bouncing box.
module video_pattern_gen #(
    parameter int H_VISIBLE = video_pkg::H_VISIBLE,
    parameter int V_VISIBLE = video_pkg::V_VISIBLE,
    parameter int BOX_SIZE  = 64,
    parameter int BOX_STEP  = 2
) (
    input  logic pixel_clk_in,
    input  logic rst_in,
    video_pattern_gen_if.slave bus
);

    import video_pkg::*;

    logic          frame_tick;
    pattern_mode_t mode_q;
    logic [10:0]   box_x;
    logic [9:0]    box_y;

    logic [12:0]   x_ext;
    logic [12:0]   bx_lo;
    logic [12:0]   bx_hi;
    logic [10:0]   y_ext;
    logic [10:0]   by_lo;
    logic [10:0]   by_hi;
    logic          box_hit;
    logic          tile;
    logic [23:0]   pix_rgb;

    logic          s1_hs;
    logic          s1_vs;
    logic          s1_de;
    logic [23:0]   s1_rgb;

    // Single cycle in vertical blanking; never on a visible pixel.
    assign frame_tick = (bus.x_in == '0)
                     && (bus.y_in == 10'(V_VISIBLE));

    pattern_box_mover #(
        .H_VISIBLE (H_VISIBLE),
        .V_VISIBLE (V_VISIBLE),
        .BOX_SIZE  (BOX_SIZE),
        .BOX_STEP  (BOX_STEP)
    ) u_box (
        .clk        (pixel_clk_in),
        .rst        (rst_in),
        .frame_tick (frame_tick),
        .box_x      (box_x),
        .box_y      (box_y)
    );

    assign x_ext = {1'b0, bus.x_in};
    assign bx_lo = {2'b00, box_x};
    assign bx_hi = bx_lo + 13'(BOX_SIZE);
    assign y_ext = {1'b0, bus.y_in};
    assign by_lo = {1'b0, box_y};
    assign by_hi = by_lo + 11'(BOX_SIZE);

    assign box_hit = (x_ext >= bx_lo) && (x_ext < bx_hi)
                  && (y_ext >= by_lo) && (y_ext < by_hi);

    assign tile = bus.x_in[5] ^ bus.y_in[5];

    always_comb begin
        pix_rgb = '0;
        unique case (mode_q)
            PAT_BARS:  pix_rgb = BAR_TABLE[bar_index(bus.x_in)];
            PAT_GRAD:  pix_rgb = {3{bus.x_in[10:3]}};
            PAT_CHECK: pix_rgb = tile ? {3{bus.fc_in, 2'b00}} : '0;
            PAT_BOX:   pix_rgb = box_hit ? 24'hFFFFFF : 24'h0000FF;
            default:   pix_rgb = '0;
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            mode_q        <= PAT_BARS;
            s1_hs         <= 1'b0;
            s1_vs         <= 1'b0;
            s1_de         <= 1'b0;
            s1_rgb        <= '0;
            bus.hs_out    <= 1'b0;
            bus.vs_out    <= 1'b0;
            bus.de_out    <= 1'b0;
            bus.red_out   <= '0;
            bus.green_out <= '0;
            bus.blue_out  <= '0;
        end else begin
            if (frame_tick)
                mode_q <= pattern_mode_t'(bus.mode_in);
            s1_hs         <= bus.hs_in;
            s1_vs         <= bus.vs_in;
            s1_de         <= bus.active_in;
            s1_rgb        <= bus.active_in ? pix_rgb : '0;
            bus.hs_out    <= s1_hs;
            bus.vs_out    <= s1_vs;
            bus.de_out    <= s1_de;
            bus.red_out   <= s1_rgb[23:16];
            bus.green_out <= s1_rgb[15:8];
            bus.blue_out  <= s1_rgb[7:0];
        end
    end

endmodule
